morra_cinese: RTL and testbench
===============================

Name: morra_cinese

Overview:
- Synchronous rock-paper-scissors ("morra cinese") referee for two players, built as an FSM plus datapath.
- Each clock the block samples both players' moves and scores the round, tracking wins and rounds played.
- It declares the game result when the game ends.
- Game length is configured at game start from the move inputs.

Parameters:
- none (all widths fixed)

Ports:
- clk    in   1  system clock; all state updates on rising edge
- rst    in   1  synchronous active-high reset
- P1     in   2  player-1 move: 00 invalid, 01 rock, 10 paper, 11 scissors; while START=1 it is the high half of the round-count setting
- P2     in   2  player-2 move (same encoding); while START=1 it is the low half of the round-count setting
- START  in   1  start/restart a game (synchronous, sampled each edge)
- ROUND  out  2  registered round result: 00 invalid/no round, 01 P1 won round, 10 P2 won round, 11 tie
- GAME   out  2  registered game result: 00 game not finished, 01 P1 wins game, 10 P2 wins game, 11 game tied

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Outputs: both outputs are registered. The result of the inputs sampled at edge N is visible after edge N until edge N+1.
- Priority: rst > START > normal play.

Reset:
- rst=1: state IDLE, all counters and the last-winner record cleared, max_rounds=4, ROUND=00, GAME=00.

START=1 (any state):
- Load max_rounds = {P1,P2} + 4 as a 5-bit value, range 4..19.
- Clear wins1, wins2, played (5-bit each) and the last-winner record.
- Go to PLAY; ROUND=00, GAME=00.
- Repeated START cycles reload the configuration; the last one wins.

IDLE, START=0:
- Moves ignored, no counters change; ROUND=00, GAME=00.

PLAY, START=0, each edge scores one round:
- Invalid round, in either case below: ROUND=00, GAME=00, no counter or record change, stay in PLAY.
  - Either move is 00.
  - The previous valid round's winner repeats the exact move they won with.
- Valid round, outcome:
  - Rock beats scissors, scissors beats paper, paper beats rock; equal moves tie.
  - ROUND=01, 10 or 11 accordingly; played += 1.
  - Winner's win counter += 1.
  - Last-winner record := winner and their move; a tie clears the record.
- Game end is checked after the update. The game ends if either holds:
  - played >= 4 and |wins1 - wins2| >= 2;
  - played == max_rounds.
- On end: GAME = 01 if wins1>wins2, 10 if wins2>wins1, 11 if equal; next state IDLE.
- GAME is non-zero for exactly one cycle; it returns to 00 on the next edge in IDLE.
- Otherwise GAME=00 and the block stays in PLAY.
- Counters cannot exceed 19, so no wrap-around is possible.
- rst mid-game aborts the game immediately; outputs go to 00.

Test Plan:
- Min-length tie-break: START with P1=00,P2=00 (max 4); then 01/01, 10/10, 11/11 give ROUND=11 ×3; 00/00 gives ROUND=00; 01/10 gives ROUND=10, GAME=10; next cycle 01/01 in IDLE gives ROUND=00, GAME=00.
- Reconfigure and max-rounds end: START 00/00, then START 00/01 (max 5). Rounds:
  - 01/10: ROUND=10
  - 01/11: ROUND=01
  - 10/01: ROUND=01
  - 11/11: ROUND=11
  - 11/00: ROUND=00 (invalid)
  - 10/01: ROUND=01, GAME=01 (3-1 at round 5)
- Early end on a 2-win margin: START 00/00; P1 wins 4 straight without repeating a winning move (01/11, 11/10, 10/01, 01/11) → GAME=01 after round 4. Repeat with P2 winning (e.g. 3-1) → GAME=10.
- Repeat-move rule: P1 wins with 01/11; next 01/11 gives ROUND=00 and played unchanged; next 10/01 gives ROUND=01.
- Max 19 rounds: START P1=11,P2=11; alternate wins and ties so the margin stays <2; GAME asserts exactly on the 19th valid round with the correct winner/tie code.
- Reset: assert rst mid-game → ROUND=00, GAME=00 next cycle; play inputs are then ignored until START.

Source files
------------

// File: rtl/morra_cinese.sv
// morra_cinese: synchronous rock-paper-scissors referee for two players.
//
// The block scores one round on every clock edge while a game is in
// progress. It counts wins for each player and the number of valid rounds
// played, and it declares the game result when the game ends.
//
// Ports:
//   clk    in  1  system clock; all state updates happen on the rising edge
//   rst    in  1  synchronous active-high reset
//   P1     in  2  player-1 move (00 invalid, 01 rock, 10 paper, 11 scissors);
//                 while START=1 it is the high half of the round-count setting
//   P2     in  2  player-2 move (same encoding); while START=1 it is the
//                 low half of the round-count setting
//   START  in  1  start or restart a game
//   ROUND  out 2  registered round result (00 none/invalid, 01 P1, 10 P2, 11 tie)
//   GAME   out 2  registered game result, non-zero for exactly one cycle
//                 (00 running/idle, 01 P1 wins, 10 P2 wins, 11 tie)
module morra_cinese (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] P1,
  input  logic [1:0] P2,
  input  logic       START,
  output logic [1:0] ROUND,
  output logic [1:0] GAME
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_TIE  = 2'b11;

  state_t     state_q, state_d;
  logic [4:0] max_q, max_d;
  logic [4:0] wins1_q, wins1_d;
  logic [4:0] wins2_q, wins2_d;
  logic [4:0] played_q, played_d;
  // Last-winner record: which player won the previous valid round (RES_NONE
  // after a tie or at game start) and the move they won with.
  logic [1:0] lwin_q, lwin_d;
  logic [1:0] lmove_q, lmove_d;
  logic [1:0] round_q, round_d;
  logic [1:0] game_q, game_d;

  logic [1:0] outcome;
  logic       repeat_mv;
  logic       valid_rnd;
  logic [4:0] margin;

  // Rock beats scissors, scissors beats paper, paper beats rock.
  function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
    if (a == b)
      return RES_TIE;
    else if ((a == 2'b01 && b == 2'b11) ||
             (a == 2'b11 && b == 2'b10) ||
             (a == 2'b10 && b == 2'b01))
      return RES_P1;
    else
      return RES_P2;
  endfunction

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    wins1_d   = wins1_q;
    wins2_d   = wins2_q;
    played_d  = played_q;
    lwin_d    = lwin_q;
    lmove_d   = lmove_q;
    round_d   = RES_NONE;
    game_d    = RES_NONE;
    outcome   = judge(P1, P2);
    // The previous winner may not reuse the exact move they won with.
    repeat_mv = ((lwin_q == RES_P1) && (P1 == lmove_q)) ||
                ((lwin_q == RES_P2) && (P2 == lmove_q));
    valid_rnd = (P1 != 2'b00) && (P2 != 2'b00) && !repeat_mv;
    margin    = 5'd0;

    if (START) begin
      max_d    = {1'b0, P1, P2} + 5'd4;
      wins1_d  = 5'd0;
      wins2_d  = 5'd0;
      played_d = 5'd0;
      lwin_d   = RES_NONE;
      lmove_d  = 2'b00;
      state_d  = PLAY;
    end else if (state_q == PLAY && valid_rnd) begin
      round_d  = outcome;
      played_d = played_q + 5'd1;
      case (outcome)
        RES_P1: begin
          wins1_d = wins1_q + 5'd1;
          lwin_d  = RES_P1;
          lmove_d = P1;
        end
        RES_P2: begin
          wins2_d = wins2_q + 5'd1;
          lwin_d  = RES_P2;
          lmove_d = P2;
        end
        default: begin
          lwin_d  = RES_NONE;
          lmove_d = 2'b00;
        end
      endcase

      // End-of-game test uses the counts after this round's update.
      margin = (wins1_d >= wins2_d) ? (wins1_d - wins2_d) : (wins2_d - wins1_d);
      if ((played_d >= 5'd4 && margin >= 5'd2) || played_d == max_q) begin
        if (wins1_d > wins2_d)
          game_d = RES_P1;
        else if (wins2_d > wins1_d)
          game_d = RES_P2;
        else
          game_d = RES_TIE;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      max_q    <= 5'd4;
      wins1_q  <= 5'd0;
      wins2_q  <= 5'd0;
      played_q <= 5'd0;
      lwin_q   <= RES_NONE;
      lmove_q  <= 2'b00;
      round_q  <= RES_NONE;
      game_q   <= RES_NONE;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      wins1_q  <= wins1_d;
      wins2_q  <= wins2_d;
      played_q <= played_d;
      lwin_q   <= lwin_d;
      lmove_q  <= lmove_d;
      round_q  <= round_d;
      game_q   <= game_d;
    end
  end

  assign ROUND = round_q;
  assign GAME  = game_q;

endmodule

// File: tb/tb_morra_cinese.sv
// Directed testbench for morra_cinese. Each step drives one set of inputs
// on the falling edge and checks ROUND/GAME shortly after the next rising
// edge against hand-computed values.
module tb_morra_cinese;

  logic       clk;
  logic       rst;
  logic [1:0] P1;
  logic [1:0] P2;
  logic       START;
  logic [1:0] ROUND;
  logic [1:0] GAME;

  int errors = 0;
  int checks = 0;

  morra_cinese dut (
    .clk   (clk),
    .rst   (rst),
    .P1    (P1),
    .P2    (P2),
    .START (START),
    .ROUND (ROUND),
    .GAME  (GAME)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic st, input logic [1:0] p1,
                      input logic [1:0] p2, input logic [1:0] exp_round,
                      input logic [1:0] exp_game, input string tag);
    @(negedge clk);
    rst   = r;
    START = st;
    P1    = p1;
    P2    = p2;
    @(posedge clk);
    #1;
    checks++;
    assert (ROUND === exp_round && GAME === exp_game)
    else begin
      errors++;
      $error("FAIL %s: got ROUND=%b GAME=%b, want ROUND=%b GAME=%b",
             tag, ROUND, GAME, exp_round, exp_game);
    end
  endtask

  initial begin
    rst = 1'b1; START = 1'b0; P1 = 2'b00; P2 = 2'b00;

    // Reset state
    step(1, 0, 2'b01, 2'b10, 2'b00, 2'b00, "reset0");
    step(1, 1, 2'b01, 2'b10, 2'b00, 2'b00, "reset_over_start");
    step(0, 0, 2'b01, 2'b11, 2'b00, 2'b00, "idle_ignores");

    // Min-length game, decided at round 4
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, "t1_start");
    step(0, 0, 2'b01, 2'b01, 2'b11, 2'b00, "t1_tie1");
    step(0, 0, 2'b10, 2'b10, 2'b11, 2'b00, "t1_tie2");
    step(0, 0, 2'b11, 2'b11, 2'b11, 2'b00, "t1_tie3");
    step(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, "t1_invalid");
    step(0, 0, 2'b01, 2'b10, 2'b10, 2'b10, "t1_end");
    step(0, 0, 2'b01, 2'b01, 2'b00, 2'b00, "t1_idle");

    // Reconfigure to 5 rounds, end on max rounds
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, "t2_start_a");
    step(0, 1, 2'b00, 2'b01, 2'b00, 2'b00, "t2_start_b");
    step(0, 0, 2'b01, 2'b10, 2'b10, 2'b00, "t2_r1");
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b00, "t2_r2");
    step(0, 0, 2'b10, 2'b01, 2'b01, 2'b00, "t2_r3");
    step(0, 0, 2'b11, 2'b11, 2'b11, 2'b00, "t2_r4");
    step(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, "t2_invalid");
    step(0, 0, 2'b10, 2'b01, 2'b01, 2'b01, "t2_end");
    step(0, 0, 2'b10, 2'b01, 2'b00, 2'b00, "t2_idle");

    // Early end on a 2-win margin, P1 4-0
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, "t3_start");
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b00, "t3_r1");
    step(0, 0, 2'b11, 2'b10, 2'b01, 2'b00, "t3_r2");
    step(0, 0, 2'b10, 2'b01, 2'b01, 2'b00, "t3_r3");
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b01, "t3_end");

    // Early end, P2 3-1
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, "t4_start");
    step(0, 0, 2'b11, 2'b01, 2'b10, 2'b00, "t4_r1");
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b00, "t4_r2");
    step(0, 0, 2'b10, 2'b11, 2'b10, 2'b00, "t4_r3");
    step(0, 0, 2'b11, 2'b01, 2'b10, 2'b10, "t4_end");

    // Repeat-move rule; a tie clears the record
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, "t5_start");
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b00, "t5_r1");
    step(0, 0, 2'b01, 2'b11, 2'b00, 2'b00, "t5_repeat");
    step(0, 0, 2'b10, 2'b01, 2'b01, 2'b00, "t5_r2");
    step(0, 0, 2'b11, 2'b11, 2'b11, 2'b00, "t5_tie");
    step(0, 0, 2'b10, 2'b01, 2'b01, 2'b01, "t5_end");

    // 19-round game: P1 win, P2 win, tie repeated, P1 takes the last round
    step(0, 1, 2'b11, 2'b11, 2'b00, 2'b00, "t6_start");
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 2'b01, 2'b11, 2'b01, 2'b00, "t6_p1");
      step(0, 0, 2'b11, 2'b01, 2'b10, 2'b00, "t6_p2");
      step(0, 0, 2'b10, 2'b10, 2'b11, 2'b00, "t6_tie");
    end
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b01, "t6_end19");
    step(0, 0, 2'b10, 2'b01, 2'b00, 2'b00, "t6_idle");

    // Reset mid-game aborts; play is ignored until START
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, "t7_start");
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b00, "t7_r1");
    step(1, 0, 2'b10, 2'b01, 2'b00, 2'b00, "t7_rst");
    step(0, 0, 2'b10, 2'b01, 2'b00, 2'b00, "t7_after_rst1");
    step(0, 0, 2'b11, 2'b10, 2'b00, 2'b00, "t7_after_rst2");
    step(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, "t7_restart");
    step(0, 0, 2'b01, 2'b11, 2'b01, 2'b00, "t7_play");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
